periph_target_adapter_pe: RTL and testbench

- Slave-side terminator of the peripheral interconnect request/response protocol; one instance sits on each slave port of the interconnect.
- Accepts the arbitrated request (req/add/wen/wdata/be/ID with grant flow control) and forwards it to a peripheral backend.
- Tracks the one-hot master ID of every outstanding transaction in an in-order queue.
- Returns registered r_valid/r_ID/r_rdata/r_opc, so the interconnect's response decoder can route data back to the originating master.

---
 rtl/periph_interco_pkg.sv | 17 +
 rtl/periph_id_fifo.sv | 64 ++++++
 rtl/periph_target_adapter_pe.sv | 106 ++++++++++
 tb/tb_periph_target_adapter_pe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_interco_pkg.sv
// Shared definitions for the peripheral interconnect: response opcodes and
// width helpers for the per-port occupancy counter and queue pointers.
package periph_interco_pkg;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  // The counter must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/periph_id_fifo.sv
// In-order FIFO of one-hot master IDs; head is presented combinationally so a
// response can be tagged in the same cycle it is popped.
module periph_id_fifo
  import periph_interco_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 16,
  parameter int CNT_W    = count_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [ID_WIDTH-1:0] data_i,
  input  logic                pop_i,
  output logic [ID_WIDTH-1:0] data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CNT_W-1:0]    count_o
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [ID_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/periph_target_adapter_pe.sv
// Slave-port terminator: gates requests on queue occupancy, forwards them to the
// backend and returns registered responses tagged with the originating master ID.
module periph_target_adapter_pe
  import periph_interco_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int N_CH0      = 16,
  parameter int ID_WIDTH   = N_CH0,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  data_r_valid_o,
  output logic [ID_WIDTH-1:0]   data_r_ID_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  output logic                  per_req_o,
  output logic [ADDR_WIDTH-1:0] per_add_o,
  output logic                  per_wen_o,
  output logic [DATA_WIDTH-1:0] per_wdata_o,
  output logic [BE_WIDTH-1:0]   per_be_o,
  input  logic                  per_gnt_i,
  input  logic                  per_r_valid_i,
  input  logic [DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic                  per_r_opc_i,
  output logic                  err_o
);

  localparam int CNT_W = count_width(DEPTH);

  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ID_WIDTH-1:0]   head_id;
  logic                  push, pop;

  logic                  r_valid_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic                  r_opc_q;
  logic                  err_q;

  // Gating uses registered occupancy only, so a same-cycle pop cannot open the grant.
  assign per_req_o   = data_req_i & ~fifo_full;
  assign data_gnt_o  = per_gnt_i & ~fifo_full;
  assign per_add_o   = data_add_i;
  assign per_wen_o   = data_wen_i;
  assign per_wdata_o = data_wdata_i;
  assign per_be_o    = data_be_i;

  assign push = data_req_i & data_gnt_o;
  assign pop  = per_r_valid_i & ~fifo_empty;

  periph_id_fifo #(
    .DEPTH   (DEPTH),
    .ID_WIDTH(ID_WIDTH),
    .CNT_W   (CNT_W)
  ) u_id_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (data_ID_i),
    .pop_i  (pop),
    .data_o (head_id),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == CNT_W'(DEPTH)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_rdata_q <= '0;
      r_opc_q   <= OPC_OK;
      err_q     <= 1'b0;
    end else begin
      r_valid_q <= pop;
      if (pop) begin
        r_id_q    <= head_id;
        r_rdata_q <= per_r_rdata_i;
        r_opc_q   <= per_r_opc_i;
      end
      // A backend response with nothing outstanding is a protocol violation.
      if (per_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign data_r_valid_o = r_valid_q;
  assign data_r_ID_o    = r_id_q;
  assign data_r_rdata_o = r_rdata_q;
  assign data_r_opc_o   = r_opc_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_periph_target_adapter_pe.sv
// Directed bench for periph_target_adapter_pe with a scoreboard of expected responses.
module tb_periph_target_adapter_pe;

  localparam int AW = 32, DW = 32, BW = 4, IW = 16, D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_req_i = 1'b0;
  logic [AW-1:0] data_add_i = '0;
  logic          data_wen_i = 1'b1;
  logic [DW-1:0] data_wdata_i = '0;
  logic [BW-1:0] data_be_i = '0;
  logic [IW-1:0] data_ID_i = '0;
  logic          data_gnt_o, data_r_valid_o, data_r_opc_o;
  logic [IW-1:0] data_r_ID_o;
  logic [DW-1:0] data_r_rdata_o;
  logic          per_req_o, per_wen_o;
  logic [AW-1:0] per_add_o;
  logic [DW-1:0] per_wdata_o;
  logic [BW-1:0] per_be_o;
  logic          per_gnt_i = 1'b1;
  logic          per_r_valid_i = 1'b0;
  logic [DW-1:0] per_r_rdata_i = '0;
  logic          per_r_opc_i = 1'b0;
  logic          err_o;

  periph_target_adapter_pe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .N_CH0(IW), .ID_WIDTH(IW), .DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o), .data_r_ID_o(data_r_ID_o),
    .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
    .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
    .per_wdata_o(per_wdata_o), .per_be_o(per_be_o), .per_gnt_i(per_gnt_i),
    .per_r_valid_i(per_r_valid_i), .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] rdata;
    logic          opc;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] id_q[$];
  logic          err_exp = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every presented response must match the scoreboard head, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_r_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got valid ID %0h expected no response (cycle %0d)",
                   data_r_ID_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 64'(data_r_ID_o), 64'(e.id));
          chk("rsp_rdata", 64'(data_r_rdata_o), 64'(e.rdata));
          chk("rsp_opc", 64'(data_r_opc_o), 64'(e.opc));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rsp: got no response expected ID %0h due cycle %0d (cycle %0d)",
                 e.id, e.due, cyc);
      end
    end
  end

  // One clock of stimulus; exp_gnt is the hand-derived grant for this cycle.
  task automatic step(input logic req, input logic [IW-1:0] id, input logic wen,
                      input logic [AW-1:0] addr, input logic rv, input logic [DW-1:0] rdata,
                      input logic opc, input logic exp_gnt);
    exp_t e;
    logic spurious;
    data_req_i    = req;
    data_ID_i     = id;
    data_wen_i    = wen;
    data_add_i    = addr;
    data_wdata_i  = ~addr;
    data_be_i     = addr[3:0];
    per_gnt_i     = 1'b1;
    per_r_valid_i = rv;
    per_r_rdata_i = rdata;
    per_r_opc_i   = opc;
    spurious = rv && (id_q.size() == 0);
    if (rv && !spurious) begin
      e.id    = id_q.pop_front();
      e.rdata = rdata;
      e.opc   = opc;
      e.due   = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("gnt", 64'(data_gnt_o), 64'(exp_gnt));
    chk("per_req", 64'(per_req_o), 64'(req & exp_gnt));
    chk("err", 64'(err_o), 64'(err_exp));
    if (req) begin
      chk("pass_add", 64'(per_add_o), 64'(addr));
      chk("pass_wen_wdata_be", {31'b0, per_wen_o, per_wdata_o} ^ 64'(per_be_o),
          {31'b0, wen, ~addr} ^ 64'(addr[3:0]));
    end
    if (req && exp_gnt) id_q.push_back(id);
    @(posedge clk);
    #1;
    if (spurious) err_exp = 1'b1;
    data_req_i    = 1'b0;
    per_r_valid_i = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input logic check_pre);
    rst_n         = 1'b0;
    data_req_i    = 1'b0;
    per_r_valid_i = 1'b0;
    @(negedge clk);
    if (check_pre) chk("err_before_rst", 64'(err_o), 64'(err_exp));
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    id_q.delete();
    exp_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(data_r_valid_o), 64'h0);
    chk("rst_id", 64'(data_r_ID_o), 64'h0);
    chk("rst_rdata", 64'(data_r_rdata_o), 64'h0);
    chk("rst_opc", 64'(data_r_opc_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Single read
    step(1'b1, 16'h0004, 1'b1, 32'h0000_1000, 1'b0, '0, 1'b0, 1'b1);
    idle();
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    idle();
    idle();

    // Fill to full, fifth request refused, then drain in order
    step(1'b1, 16'h0001, 1'b1, 32'h0000_0010, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0002, 1'b0, 32'h0000_0024, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0004, 1'b1, 32'h0000_0038, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0008, 1'b0, 32'h0000_004C, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0010, 1'b1, 32'h0000_0050, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'h2222_2222, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'h3333_3333, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'h4444_4444, 1'b1, 1'b1);
    idle();

    // Simultaneous push/pop at count 2; count proven still 2 by refill limit
    step(1'b1, 16'h0020, 1'b1, 32'h0000_0100, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0040, 1'b1, 32'h0000_0104, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0080, 1'b0, 32'h0000_0108, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
    step(1'b1, 16'h0100, 1'b1, 32'h0000_010C, 1'b1, 32'hA5A5_0002, 1'b0, 1'b1);
    step(1'b1, 16'h0400, 1'b1, 32'h0000_0110, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0800, 1'b1, 32'h0000_0114, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h1000, 1'b1, 32'h0000_0118, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hA5A5_0003, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hA5A5_0004, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hA5A5_0005, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hA5A5_0006, 1'b0, 1'b1);
    idle();

    // Full with a pop in the same cycle: no grant until the next cycle
    step(1'b1, 16'h0001, 1'b1, 32'h0000_0200, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0002, 1'b1, 32'h0000_0204, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0004, 1'b1, 32'h0000_0208, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0008, 1'b1, 32'h0000_020C, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0200, 1'b1, 32'h0000_0210, 1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
    step(1'b1, 16'h0200, 1'b1, 32'h0000_0210, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hC0DE_0002, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hC0DE_0003, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hC0DE_0004, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hC0DE_0005, 1'b1, 1'b1);
    idle();

    // Spurious response while empty: sticky error until reset
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hBAD0_0001, 1'b0, 1'b1);
    idle();
    idle();
    do_reset(1'b1);

    // Reset with three outstanding discards them; a late response is spurious
    step(1'b1, 16'h0001, 1'b1, 32'h0000_0300, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0002, 1'b1, 32'h0000_0304, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0004, 1'b1, 32'h0000_0308, 1'b0, '0, 1'b0, 1'b1);
    do_reset(1'b1);
    step(1'b0, '0, 1'b1, '0, 1'b1, 32'hBAD0_0002, 1'b0, 1'b1);
    idle();
    idle();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
